random_byte_packer: RTL

- Sits directly downstream of the random bit generator.
- Consumes its single-cycle random_bit / random_bit_ready strobes and runs a repetition-count health test on the raw bit stream.
- Packs healthy bits into bytes and buffers them in a small first-word-fall-through FIFO.
- Presents bytes on a valid/ready stream to the host-link transmitter, e.g. the UART TX.

---
 rtl/qrng_pkg.sv | 13 +
 rtl/byte_fifo.sv | 57 +++++
 rtl/random_byte_packer.sv | 112 +++++++++++
 3 files changed

// File: rtl/qrng_pkg.sv
// Shared constants and state encoding for the random byte packing path.
package qrng_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEF_REP_LIMIT  = 32;
    localparam int DEF_FIFO_DEPTH = 16;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is visible whenever not empty.
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LEVEL_MAX);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/random_byte_packer.sv
// Repetition-count health test on the raw random bit stream, LSB-first byte packing, FWFT byte buffer.
//   state    | meaning
//   ST_RUN   | bits accepted, tested and packed
//   ST_FAULT | run limit tripped; bits ignored until clear_flags, FIFO keeps draining
module random_byte_packer
    import qrng_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          random_bit,
    input  logic                          random_bit_ready,
    input  logic                          clear_flags,
    output logic [BYTE_W-1:0]             byte_data,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          health_fail
);

    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT);

    state_e              state_q;
    logic [BYTE_W-2:0]   shift_q;
    logic [BYTE_W-2:0]   shift_d;
    logic [2:0]          bitcnt_q;
    logic [RW-1:0]       run_q;
    logic [RW-1:0]       run_d;
    logic                last_q;
    logic                overflow_q;
    logic                health_q;

    logic                accept;
    logic                trip;
    logic                push;
    logic [BYTE_W-1:0]   push_data;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                drop;

    // A clear on the same cycle as a strobe wins; that bit is lost.
    assign accept = random_bit_ready && (state_q == ST_RUN) && !clear_flags;

    always_comb begin
        run_d = RW'(1);
        if (run_q != '0 && random_bit == last_q)
            run_d = (run_q == REP_MAX) ? REP_MAX : run_q + RW'(1);
    end

    assign trip      = accept && (run_d == REP_MAX);
    assign shift_d   = {random_bit, shift_q[BYTE_W-2:1]};
    assign push      = accept && !trip && (bitcnt_q == 3'd7);
    assign push_data = {random_bit, shift_q};
    assign pop       = byte_valid && byte_ready;
    assign drop      = push && fifo_full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            run_q      <= '0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
            health_q   <= 1'b0;
        end else if (clear_flags) begin
            state_q    <= ST_RUN;
            run_q      <= '0;
            overflow_q <= 1'b0;
            health_q   <= 1'b0;
        end else begin
            if (drop) overflow_q <= 1'b1;
            if (accept) begin
                last_q <= random_bit;
                run_q  <= run_d;
                if (trip) begin
                    health_q <= 1'b1;
                    state_q  <= ST_FAULT;
                    bitcnt_q <= '0;
                end else begin
                    shift_q  <= shift_d;
                    bitcnt_q <= bitcnt_q + 3'd1;
                end
            end
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .rd_data_o   (byte_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    assign byte_valid  = !fifo_empty;
    assign overflow    = overflow_q;
    assign health_fail = health_q;

endmodule
